// File: rtl/gray_input_conditioner.sv
// -----------------------------------------------------------------------------
// gray_input_conditioner
//
// Captures a Gray code from asynchronous board switches, synchronises and
// debounces it, converts the committed code to binary and holds the result
// for the downstream binary-to-7-segment display stage.
//
// Parameters:
//   WIDTH            Gray/binary word width.
//   SYNC_STAGES      Flip-flop stages in the input synchroniser (>= 2).
//   DEBOUNCE_CYCLES  Consecutive stable cycles required before commit (>= 2).
//
// Ports:
//   clk        in   1      System clock, rising edge.
//   rst        in   1      Synchronous, active-high reset.
//   gray_in    in   WIDTH  Raw Gray code from switches (asynchronous, bouncy).
//   bin_out    out  WIDTH  Last committed value in binary; stable between updates.
//   bin_valid  out  1      High once a value has been committed since reset.
//   update     out  1      One-cycle pulse on the cycle bin_out takes a new value.
//   step_err   out  1      Sticky: a committed change was not a single-bit Gray step.
//
// Optional feature:
//   GRAY_ADJACENCY_CHECK_EN  When defined, step_err is built and set on any
//                            non-first committed change whose Gray codes differ
//                            in more than one bit. When undefined, step_err is 0.
// -----------------------------------------------------------------------------
module gray_input_conditioner #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             update,
    output logic             step_err
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        STABLE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sync_p [SYNC_STAGES];
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] committed;
    logic [CNT_W-1:0] cnt;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

`ifdef GRAY_ADJACENCY_CHECK_EN
    function automatic int unsigned popcount(input logic [WIDTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction
`endif

    // Synchroniser chain: stage 0 samples the asynchronous switches.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_p[i] <= '0;
            end
        end else begin
            sync_p[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_p[i] <= sync_p[i-1];
            end
        end
    end

    assign sync_q = sync_p[SYNC_STAGES-1];

    // Debounce FSM with registered outputs. The counter is only advanced while
    // below CNT_LAST, so it saturates at the commit condition and never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            committed <= '0;
            bin_out   <= '0;
            bin_valid <= 1'b0;
            update    <= 1'b0;
`ifdef GRAY_ADJACENCY_CHECK_EN
            step_err  <= 1'b0;
`endif
        end else begin
            update <= 1'b0;
            case (state)
                // Compared against the reset candidate unconditionally, so an
                // all-zero input also has to prove itself stable before commit.
                IDLE: begin
                    cand  <= sync_q;
                    cnt   <= '0;
                    state <= SETTLE;
                end
                SETTLE: begin
                    if (sync_q != cand) begin
                        cand <= sync_q;
                        cnt  <= '0;
                    end else if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        state <= STABLE;
                        // A bounce that settles back on the held value commits
                        // nothing, so the display sees no spurious update.
                        if (!bin_valid || (cand != committed)) begin
                            committed <= cand;
                            bin_out   <= gray2bin(cand);
                            bin_valid <= 1'b1;
                            update    <= 1'b1;
`ifdef GRAY_ADJACENCY_CHECK_EN
                            if (bin_valid && (popcount(cand ^ committed) > 1)) begin
                                step_err <= 1'b1;
                            end
`endif
                        end
                    end
                end
                STABLE: begin
                    if (sync_q != committed) begin
                        cand  <= sync_q;
                        cnt   <= '0;
                        state <= SETTLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef GRAY_ADJACENCY_CHECK_EN
    assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_input_conditioner.sv
module tb_gray_input_conditioner;

    logic       clk;
    logic       rst;
    logic [3:0] gray_in;
    logic [3:0] bin_out;
    logic       bin_valid;
    logic       update;
    logic       step_err;

    typedef struct {
        int bin;
        int edge_no;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp;
    int         n_fail;
    int         cyc;
    bit         done;
    logic [3:0] gray_tbl [16];

    gray_input_conditioner #(
        .WIDTH          (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .gray_in  (gray_in),
        .bin_out  (bin_out),
        .bin_valid(bin_valid),
        .update   (update),
        .step_err (step_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute rising-edge number; after posedge N it reads N.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp = n_cmp + 1;
        if (act != req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Leaves the stimulus 1 time unit after a rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds rst for 3 edges with gray_in at g; returns with rst released.
    task automatic do_reset(input logic [3:0] g);
        rst     = 1'b1;
        gray_in = g;
        step(3);
        rst = 1'b0;
    endtask

    // Applies g now (edge 1 is the next rising edge) and expects a commit of
    // bin_val on relative edge 7 (SYNC_STAGES + DEBOUNCE_CYCLES + 1).
    task automatic apply_commit(input logic [3:0] g, input int bin_val, input int hold);
        exp_t e;
        gray_in   = g;
        e.bin     = bin_val;
        e.edge_no = cyc + 7;
        exp_q.push_back(e);
        step(hold);
    endtask

    task automatic monitor();
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (update === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp  = n_cmp + 1;
                    n_fail = n_fail + 1;
                    $display("FAIL unexpected_update: got update with bin_out=%0d at edge %0d, expected none",
                             bin_out, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("commit_value", int'(bin_out), e.bin);
                    check("commit_edge", cyc, e.edge_no);
                    check("commit_valid", int'(bin_valid), 1);
                end
            end
        end
    endtask

    task automatic stimulus();
        exp_t e;
        int   r;

        // Reset state
        do_reset(4'b0000);
        check("rst_bin_out", int'(bin_out), 0);
        check("rst_bin_valid", int'(bin_valid), 0);
        check("rst_update", int'(update), 0);
        check("rst_step_err", int'(step_err), 0);

        // First commit of 0110 -> 4 on relative edge 7
        apply_commit(4'b0110, 4, 12);
        check("commit_hold_bin", int'(bin_out), 4);

        // Glitch shorter than the debounce window: no update
        gray_in = 4'b0111;
        step(2);
        gray_in = 4'b0110;
        step(15);
        check("glitch_bin_out", int'(bin_out), 4);
        check("glitch_valid", int'(bin_valid), 1);

        // Bounce 0111/0110 every 2 cycles then settle on 0111 -> single update, 5
        for (int k = 0; k < 2; k++) begin
            gray_in = 4'b0111;
            step(2);
            gray_in = 4'b0110;
            step(2);
        end
        apply_commit(4'b0111, 5, 12);
        check("bounce_bin_out", int'(bin_out), 5);

        // Reset from a committed state returns everything to reset values
        do_reset(4'b0000);
        check("rst2_bin_out", int'(bin_out), 0);
        check("rst2_bin_valid", int'(bin_valid), 0);

        // Full sweep: zero input commits from IDLE on edge 5 after release
        r         = cyc;
        e.bin     = 0;
        e.edge_no = r + 5;
        exp_q.push_back(e);
        step(10);
        for (int i = 1; i < 16; i++) begin
            apply_commit(gray_tbl[i], i, 10);
        end
        check("sweep_last_bin", int'(bin_out), 15);
        check("sweep_step_err", int'(step_err), 0);

        // Adjacency: 0000 then 0011 (two bits change)
        do_reset(4'b0000);
        r         = cyc;
        e.bin     = 0;
        e.edge_no = r + 5;
        exp_q.push_back(e);
        step(10);
        apply_commit(4'b0011, 2, 10);
        check("adj_bin_out", int'(bin_out), 2);
`ifdef GRAY_ADJACENCY_CHECK_EN
        check("adj_step_err", int'(step_err), 1);
`else
        check("adj_step_err", int'(step_err), 0);
`endif
        do_reset(4'b0011);
        check("adj_rst_step_err", int'(step_err), 0);
        check("adj_rst_valid", int'(bin_valid), 0);

        step(3);
        done = 1'b1;
        step(2);
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        done    = 1'b0;
        rst     = 1'b1;
        gray_in = 4'b0000;
        gray_tbl[0]  = 4'b0000; gray_tbl[1]  = 4'b0001;
        gray_tbl[2]  = 4'b0011; gray_tbl[3]  = 4'b0010;
        gray_tbl[4]  = 4'b0110; gray_tbl[5]  = 4'b0111;
        gray_tbl[6]  = 4'b0101; gray_tbl[7]  = 4'b0100;
        gray_tbl[8]  = 4'b1100; gray_tbl[9]  = 4'b1101;
        gray_tbl[10] = 4'b1111; gray_tbl[11] = 4'b1110;
        gray_tbl[12] = 4'b1010; gray_tbl[13] = 4'b1011;
        gray_tbl[14] = 4'b1001; gray_tbl[15] = 4'b1000;

        fork
            monitor();
            stimulus();
        join

        n_cmp = n_cmp + 1;
        if (exp_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL missing_updates: got %0d expected commits never seen, expected 0",
                     exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
